ntt_sdf_reorder: RTL and testbench

- Streaming bit-reversal reorder buffer at the output of the SDF NTT/INTT pipeline.
- Each SDF stage hands its result to the next one coefficient per cycle, strobed by `start`. The last stage emits coefficients in bit-reversed index order.
- This block reads that stream and re-emits each polynomial in natural order, using a ping-pong pair of N-entry banks.
- Sits between the final `ntt_sdf_stage` and the polynomial sink. Natural-order bypass is available through `BITREV`.

---
 rtl/ntt_sdf_reorder.sv | 141 ++++++++++++++
 tb/tb_ntt_sdf_reorder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_sdf_reorder.sv
// Streaming bit-reversal reorder buffer for the SDF NTT pipeline output.
// A ping-pong pair of N-word banks converts each bit-reversed polynomial to natural order.
module ntt_sdf_reorder #(
  parameter int LOGQ       = 64,
  parameter int LOGN       = 10,
  parameter int DELAY_BRAM = 1,
  parameter int BITREV     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LOGQ-1:0] stage_in,
  input  logic            out_en,
  output logic            finish,
  output logic [LOGQ-1:0] stage_out,
  output logic            overflow
);

  localparam int N = 1 << LOGN;

  // Strobes: start qualifies stage_in for one cycle with no backpressure (a sample
  // arriving while both banks are full is dropped and flagged); out_en only gates
  // new read issues, and finish qualifies stage_out for exactly one cycle.

  logic [LOGQ-1:0] r_mem [0:2*N-1];
  logic [LOGN-1:0] r_wcnt;
  logic [LOGN-1:0] r_rcnt;
  logic            r_wsel;
  logic            r_rsel;
  logic [1:0]      r_full;
  logic            r_overflow;
  logic [DELAY_BRAM-1:0] r_vld;
  logic [LOGQ-1:0] r_dat [DELAY_BRAM];

  logic            w_accept;
  logic            w_drop;
  logic            w_issue;
  logic            w_wlast;
  logic            w_rlast;
  logic [LOGN-1:0] w_raddr;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = a[LOGN-1-i];
    end
    return r;
  endfunction

  // Full flags come straight from registers, so a freed bank is writable next cycle.
  assign w_accept = start & ~r_full[r_wsel];
  assign w_drop   = start &  r_full[r_wsel];
  assign w_issue  = out_en & r_full[r_rsel];
  assign w_wlast  = (r_wcnt == LOGN'(N - 1));
  assign w_rlast  = (r_rcnt == LOGN'(N - 1));

  generate
    if (BITREV != 0) begin : g_bitrev
      assign w_raddr = bitrev(r_rcnt);
    end else begin : g_identity
      assign w_raddr = r_rcnt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt     <= '0;
      r_wsel     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (w_wlast) begin
          r_wsel <= ~r_wsel;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt <= '0;
      r_rsel <= 1'b0;
    end else if (w_issue) begin
      r_rcnt <= r_rcnt + 1'b1;
      if (w_rlast) begin
        r_rsel <= ~r_rsel;
      end
    end
  end

  // Set only applies to a non-full bank and clear only to a full one, so the two
  // updates can never target the same bit in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      if (w_accept && w_wlast) begin
        r_full[r_wsel] <= 1'b1;
      end
      if (w_issue && w_rlast) begin
        r_full[r_rsel] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[{r_wsel, r_wcnt}] <= stage_in;
    end
  end

  // Each data stage only loads behind a valid, so the last stage holds stage_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < DELAY_BRAM; k++) begin
        r_dat[k] <= '0;
      end
    end else begin
      r_vld[0] <= w_issue;
      if (w_issue) begin
        r_dat[0] <= r_mem[{r_rsel, w_raddr}];
      end
      for (int k = 1; k < DELAY_BRAM; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_dat[k] <= r_dat[k-1];
        end
      end
    end
  end

  assign finish    = r_vld[DELAY_BRAM-1];
  assign stage_out = r_dat[DELAY_BRAM-1];
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ntt_sdf_reorder.sv
// Bench for ntt_sdf_reorder: three instances (bit-reversed, natural order, three-cycle
// read latency) share one stimulus stream and are checked against a FIFO-level model.
module tb_ntt_sdf_reorder;

  localparam int LOGQ = 16;
  localparam int LOGN = 4;
  localparam int N    = 16;
  localparam int NM   = 3;

  logic            clk;
  logic            tb_rst;
  logic            tb_start;
  logic [LOGQ-1:0] tb_din;
  logic            tb_out_en;
  logic            fin  [NM];
  logic [LOGQ-1:0] sout [NM];
  logic            ovf  [NM];

  int n_vec;
  int n_err;
  bit chk_en;

  ntt_sdf_reorder #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(1), .BITREV(1)) u_br (
    .clk(clk), .rst(tb_rst), .start(tb_start), .stage_in(tb_din), .out_en(tb_out_en),
    .finish(fin[0]), .stage_out(sout[0]), .overflow(ovf[0]));

  ntt_sdf_reorder #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(1), .BITREV(0)) u_nat (
    .clk(clk), .rst(tb_rst), .start(tb_start), .stage_in(tb_din), .out_en(tb_out_en),
    .finish(fin[1]), .stage_out(sout[1]), .overflow(ovf[1]));

  ntt_sdf_reorder #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(3), .BITREV(1)) u_d3 (
    .clk(clk), .rst(tb_rst), .start(tb_start), .stage_in(tb_din), .out_en(tb_out_en),
    .finish(fin[2]), .stage_out(sout[2]), .overflow(ovf[2]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int dly_of(input int m);
    return (m == 2) ? 3 : 1;
  endfunction

  function automatic bit brv_of(input int m);
    return (m != 1);
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  // Accepted samples in arrival order; f_rd counts values already issued.
  logic [LOGQ-1:0] fifo [64];
  int              f_wr;
  int              f_rd;
  logic            m_ovf;
  logic            mv   [NM][4];
  logic [LOGQ-1:0] md   [NM][4];
  logic            m_fin [NM];
  logic [LOGQ-1:0] m_out [NM];

  always @(posedge clk) begin
    int   cnt;
    int   p;
    int   i;
    int   a;
    logic iss;
    if (tb_rst) begin
      f_wr  = 0;
      f_rd  = 0;
      m_ovf = 1'b0;
      for (int m = 0; m < NM; m++) begin
        for (int k = 0; k < 4; k++) begin
          mv[m][k] = 1'b0;
          md[m][k] = '0;
        end
        m_fin[m] = 1'b0;
        m_out[m] = '0;
      end
    end else begin
      cnt = f_wr / N - f_rd / N;
      iss = tb_out_en && (cnt >= 1);
      p   = f_rd / N;
      i   = f_rd % N;
      for (int m = 0; m < NM; m++) begin
        for (int k = 3; k > 0; k--) begin
          mv[m][k] = mv[m][k-1];
          md[m][k] = md[m][k-1];
        end
        a = brv_of(m) ? int'(rev4(4'(i))) : i;
        mv[m][0] = iss;
        md[m][0] = iss ? fifo[(p * N + a) % 64] : '0;
        m_fin[m] = mv[m][dly_of(m)-1];
        if (m_fin[m]) m_out[m] = md[m][dly_of(m)-1];
      end
      if (iss) f_rd++;
      if (tb_start) begin
        if (cnt == 2) begin
          m_ovf = 1'b1;
        end else begin
          fifo[f_wr % 64] = tb_din;
          f_wr++;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    if (chk_en) begin
      for (int m = 0; m < NM; m++) begin
        chk($sformatf("model_finish[%0d]", m), 32'(fin[m]), 32'(m_fin[m]));
        chk($sformatf("model_stage_out[%0d]", m), 32'(sout[m]), 32'(m_out[m]));
        chk($sformatf("model_overflow[%0d]", m), 32'(ovf[m]), 32'(m_ovf));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic s, input logic [LOGQ-1:0] d, input logic oe);
    tb_rst    = r;
    tb_start  = s;
    tb_din    = d;
    tb_out_en = oe;
    @(posedge clk);
    #1;
    check_model();
  endtask

  // ---------------- scoreboard for directed sequences (instance u_br) ----------------
  logic [LOGQ-1:0] exp_q[$];
  int rc;
  int n_out;
  int n_extra;
  int first_c;
  int last_c;

  task automatic sb_reset();
    exp_q.delete();
    rc      = 0;
    n_out   = 0;
    n_extra = 0;
    first_c = -1;
    last_c  = -1;
  endtask

  task automatic sstep(input logic s, input logic [LOGQ-1:0] d, input logic oe);
    step(1'b0, s, d, oe);
    rc++;
    if (fin[0] === 1'b1) begin
      n_out++;
      if (first_c < 0) first_c = rc;
      last_c = rc;
      if (exp_q.size() > 0) chk("sb_data", 32'(sout[0]), 32'(exp_q.pop_front()));
      else n_extra++;
    end
  endtask

  task automatic sb_final(input string name, input int e_first, input int e_count, input int e_span);
    chk({name, "_first"}, 32'(first_c), 32'(e_first));
    chk({name, "_count"}, 32'(n_out), 32'(e_count));
    chk({name, "_span"}, 32'(last_c - first_c), 32'(e_span));
    chk({name, "_extra"}, 32'(n_extra), 32'd0);
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            start;
    logic [LOGQ-1:0] din;
    logic            oe;
    logic            e_fin;
    logic [LOGQ-1:0] e_br;
    logic [LOGQ-1:0] e_nat;
    logic            e_fin3;
  } vec_t;

  vec_t            tbl [36];
  logic [LOGQ-1:0] br_seq [16];

  initial begin
    int  c;
    int  pause_left;
    bit  paused;
    int  oe_pct;
    br_seq = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
               16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};
    for (int k = 0; k < 36; k++) begin
      c = k + 1;
      tbl[k].start  = (k < 16);
      tbl[k].din    = (k < 16) ? 16'(k) : 16'h0;
      tbl[k].oe     = 1'b1;
      tbl[k].e_fin  = (c >= 17 && c <= 32);
      tbl[k].e_br   = (c < 17) ? 16'd0 : (c <= 32) ? br_seq[c-17] : 16'd15;
      tbl[k].e_nat  = (c < 17) ? 16'd0 : (c <= 32) ? 16'(c - 17) : 16'd15;
      tbl[k].e_fin3 = (c >= 19 && c <= 34);
    end

    n_vec  = 0;
    n_err  = 0;
    chk_en = 0;

    // reset state
    step(1'b1, 1'b0, '0, 1'b0);
    chk_en = 1;
    step(1'b1, 1'b0, '0, 1'b0);
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("rst_finish[%0d]", m), 32'(fin[m]), 32'd0);
      chk($sformatf("rst_stage_out[%0d]", m), 32'(sout[m]), 32'd0);
      chk($sformatf("rst_overflow[%0d]", m), 32'(ovf[m]), 32'd0);
    end

    // basic reorder, bypass and longer read latency from the table
    for (int k = 0; k < 36; k++) begin
      step(1'b0, tbl[k].start, tbl[k].din, tbl[k].oe);
      chk($sformatf("tbl_finish_c%0d", k + 1), 32'(fin[0]), 32'(tbl[k].e_fin));
      chk($sformatf("tbl_bitrev_c%0d", k + 1), 32'(sout[0]), 32'(tbl[k].e_br));
      chk($sformatf("tbl_natural_c%0d", k + 1), 32'(sout[1]), 32'(tbl[k].e_nat));
      chk($sformatf("tbl_finish_d3_c%0d", k + 1), 32'(fin[2]), 32'(tbl[k].e_fin3));
      chk($sformatf("tbl_overflow_c%0d", k + 1), 32'(ovf[0]), 32'd0);
    end

    // back-to-back polynomials
    step(1'b1, 1'b0, '0, 1'b1);
    sb_reset();
    for (int j = 0; j < 16; j++) exp_q.push_back(br_seq[j]);
    for (int j = 0; j < 16; j++) exp_q.push_back(br_seq[j] + 16'd16);
    for (int k = 0; k < 56; k++) sstep(k < 32, (k < 32) ? 16'(k) : 16'h0, 1'b1);
    sb_final("b2b", 17, 32, 31);

    // input gaps
    step(1'b1, 1'b0, '0, 1'b1);
    sb_reset();
    for (int j = 0; j < 16; j++) exp_q.push_back(br_seq[j]);
    for (int k = 0; k < 56; k++) sstep((k < 32) && (k % 2 == 0), 16'(k / 2), 1'b1);
    sb_final("gaps", 32, 16, 15);

    // stall and overflow
    step(1'b1, 1'b0, '0, 1'b1);
    sb_reset();
    for (int j = 0; j < 16; j++) exp_q.push_back(br_seq[j]);
    for (int j = 0; j < 16; j++) exp_q.push_back(br_seq[j] + 16'd16);
    for (int k = 0; k < 40; k++) begin
      sstep(1'b1, 16'(k), 1'b0);
      if (k == 31) chk("stall_overflow_before", 32'(ovf[0]), 32'd0);
      if (k == 32) chk("stall_overflow_set", 32'(ovf[0]), 32'd1);
    end
    for (int k = 0; k < 60; k++) sstep(1'b0, '0, 1'b1);
    sb_final("stall", 41, 32, 31);
    chk("stall_overflow_held", 32'(ovf[0]), 32'd1);

    // reset mid-operation
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 16'(100 + k), 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("midrst_finish", 32'(fin[0]), 32'd0);
    chk("midrst_overflow", 32'(ovf[0]), 32'd0);
    sb_reset();
    for (int j = 0; j < 16; j++) exp_q.push_back(br_seq[j]);
    for (int k = 0; k < 40; k++) sstep(k < 16, (k < 16) ? 16'(k) : 16'h0, 1'b1);
    sb_final("midrst", 17, 16, 15);

    // mid-stream pause of out_en after five outputs
    step(1'b1, 1'b0, '0, 1'b1);
    sb_reset();
    for (int j = 0; j < 16; j++) exp_q.push_back(br_seq[j]);
    pause_left = 0;
    paused     = 0;
    for (int k = 0; k < 50; k++) begin
      logic oe;
      oe = (pause_left == 0);
      if (pause_left > 0) pause_left--;
      sstep(k < 16, (k < 16) ? 16'(k) : 16'h0, oe);
      if (!paused && n_out == 5) begin
        paused     = 1;
        pause_left = 3;
      end
    end
    sb_final("pause", 17, 16, 18);

    // randomized traffic against the model
    step(1'b1, 1'b0, '0, 1'b1);
    oe_pct = 90;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) oe_pct = ($urandom_range(0, 2) == 0) ? 10 : 90;
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 99) < 70),
           16'($urandom),
           ($urandom_range(0, 99) < oe_pct));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
